fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Parametrised instruction-fetch stage. It replaces the bare PC register plus combinational instruction memory with a decoupled front end. It owns the PC and issues requests to instruction memory over a req/gnt/rvalid protocol, which may have multi-cycle latency. Fetched {pc, instr} pairs are buffered in a small queue and handed to decode over valid/ready. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, address/data width
RESET_VECTOR, 32'h0000_0000, PC value after reset
DEPTH, 4, fetch-queue entries; also max outstanding-plus-buffered instructions (power of 2, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests (<= DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  request valid
imem_addr  out  XLEN  request address (current PC, word aligned)
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  in-order response valid
imem_rdata  in  XLEN  response instruction
redirect_valid  in  1  taken branch/jump/exception redirect
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored
dec_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
dec_pc  out  XLEN  PC of head instruction
dec_instr  out  XLEN  head instruction

Behaviour:
- Reset (rst=0, async): pc=RESET_VECTOR, queue empty, outstanding=0, drop_cnt=0. Outputs: imem_req=0, dec_valid=0, dec_pc=0, dec_instr=0.
- imem_req = !redirect_valid && (outstanding < MAX_OUTSTANDING) && (outstanding + count < DEPTH). This is combinational, so redirect blocks issue in the same cycle.
- imem_addr = {pc[XLEN-1:2], 2'b00}. Request must stay stable until granted.
- Handshake imem_req&&imem_gnt:
  - pc <= pc+4, wrapping modulo 2^XLEN.
  - Issued PC is pushed into an in-flight PC FIFO (depth MAX_OUTSTANDING).
  - outstanding++.
- Response imem_rvalid (outstanding>0):
  - outstanding--; pop the in-flight PC.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else push {pc, imem_rdata} into the queue. Latency from rvalid to dec_valid is 1 cycle.
  - The credit rule guarantees the queue is never full on a push.
- rvalid with outstanding=0 is a protocol violation: ignore it, assert in simulation.
- Decode handshake dec_valid&&dec_ready pops the head. dec_pc/dec_instr reflect the head; they hold the last value when empty.
- Redirect (redirect_valid=1), all in the same edge:
  - pc <= {redirect_pc[XLEN-1:2],2'b00}
  - queue flushed, so dec_valid=0 next cycle
  - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0)
  - any response arriving this cycle is discarded
  - a decode pop in the same cycle is still a valid consumption
  - back-to-back redirects recompute drop_cnt each cycle
- Simultaneous push and pop on the queue: count unchanged. Push into an empty queue with a pop in the same cycle is not bypassed; the entry appears next cycle.
- Steady state:
  - With zero-wait grant and 1-cycle response, throughput is 1 instr/cycle.
  - dec_ready=0 fills the queue to DEPTH, then imem_req drops.
- Reset mid-operation clears all state. Responses to pre-reset requests arriving after reset are treated as violations (see above).

Decomposition:
- Package riscv_pkg:
  - XLEN default
  - RESET_VECTOR default
  - INSTR_NOP = 32'h0000_0013
  - fetch_entry_t struct {pc, instr}
- Sub-module sync_fifo (parametrised WIDTH, DEPTH):
  - push/pop/full/empty/count, flush input, async active-low reset
  - instantiated twice: fetch queue (WIDTH=2*XLEN) and in-flight PC FIFO (WIDTH=XLEN)
- Redirect/drop logic and the credit counter stay in fetch_unit.

Test Plan:
- Reset release, 1-cycle memory, dec_ready=1 -> imem_addr 0x0,0x4,0x8... each cycle; dec_pc 0x0 first, 2 cycles after the first grant; one instr/cycle thereafter.
- dec_ready=0 for 10 cycles with a 1-cycle memory -> exactly DEPTH=4 entries buffered, imem_req=0; on release they drain in order 0x0..0xC with no loss or duplication.
- 3-cycle response latency, MAX_OUTSTANDING=2 -> never more than 2 grants without a response; dec_pc sequence contiguous.
- Redirect to 0x100 with 2 requests outstanding (PCs 0x8,0xC) -> imem_req=0 in the redirect cycle; both responses dropped; next dec_pc=0x100; queue empty the next cycle.
- Redirect coinciding with rvalid and with a dec handshake; then a second redirect to 0x203 the next cycle -> the arriving response is dropped, drop_cnt correct, next dec_pc=0x200.
- Assert rst low mid-stream with 2 outstanding -> outputs at reset values immediately; after release fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
package riscv_pkg;

   localparam int XLEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; rdata holds the last shown value while empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] hold;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? hold : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         hold  <= '0;
      end else begin
         hold <= rdata;
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the PC, issues credit-limited memory requests,
// buffers {pc, instr} for decode and discards stale responses after a redirect.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int               XLEN            = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_VECTOR    = RESET_VECTOR_DEF,
   parameter int               DEPTH           = 4,
   parameter int               MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_instr
);

   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int QCW = $clog2(DEPTH + 1);
   localparam int SW  = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   logic [XLEN-1:0]   pc;
   logic [OW-1:0]     outstanding;
   logic [OW-1:0]     drop_cnt;
   logic [SW-1:0]     credit;
   logic              issue;
   logic              rsp;
   logic              q_push;
   logic              q_pop;
   logic              q_full;
   logic              q_empty;
   logic [QCW-1:0]    q_count;
   logic [2*XLEN-1:0] q_rdata;
   logic [XLEN-1:0]   if_pc;
   logic              if_full;
   logic              if_empty;
   logic [OW-1:0]     if_count;
   logic              unused_bits;

   // Buffered plus in-flight work never exceeds DEPTH, so a response always finds room.
   assign credit    = SW'(outstanding) + SW'(q_count);
   assign imem_req  = rst && !redirect_valid && (outstanding < OW'(MAX_OUTSTANDING)) &&
                      (credit < SW'(DEPTH));
   assign imem_addr = {pc[XLEN-1:2], 2'b00};
   assign issue     = imem_req && imem_gnt;
   assign rsp       = imem_rvalid && (outstanding != '0);
   assign q_push    = rsp && (drop_cnt == '0) && !redirect_valid;
   assign q_pop     = !q_empty && dec_ready;
   assign dec_valid = !q_empty;
   assign dec_pc    = q_rdata[2*XLEN-1:XLEN];
   assign dec_instr = q_rdata[XLEN-1:0];
   assign unused_bits = ^{redirect_pc[1:0], pc[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_VECTOR;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (redirect_valid)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
         else if (issue)      pc <= pc + XLEN'(4);

         case ({issue, rsp})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         // Everything still in flight at a redirect belongs to the old path.
         if (redirect_valid)                drop_cnt <= outstanding - OW'(rsp);
         else if (rsp && drop_cnt != '0)    drop_cnt <= drop_cnt - 1'b1;
      end
   end

   sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (issue),
      .pop   (rsp),
      .wdata (imem_addr),
      .rdata (if_pc),
      .full  (if_full),
      .empty (if_empty),
      .count (if_count)
   );

   sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (q_push),
      .pop   (q_pop),
      .wdata ({if_pc, imem_rdata}),
      .rdata (q_rdata),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst)
      !(imem_rvalid && outstanding == '0));
   a_queue_room: assert property (@(posedge clk) disable iff (!rst)
      !(q_push && q_full));
   a_inflight_track: assert property (@(posedge clk) disable iff (!rst)
      (if_count == outstanding) && (if_empty == (outstanding == '0)) && !(issue && if_full));

endmodule
